// File: rtl/mac_ctrl_pkg.sv
// Shared types for the MAC array west-edge sequencer: FSM states and the
// per-row 3-bit instruction encoding.
package mac_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_LOAD,
        ST_GAP,
        ST_EXEC,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int INST_BIT_MODE = 2;
    localparam int INST_BIT_EXEC = 1;
    localparam int INST_BIT_LOAD = 0;

    typedef logic [2:0] inst_t;

    localparam inst_t INST_IDLE = 3'b000;
    localparam inst_t INST_LOAD = inst_t'(1 << INST_BIT_LOAD);
    localparam inst_t INST_EXEC = inst_t'(1 << INST_BIT_EXEC);

endpackage

// File: rtl/mac_array_ctrl_if.sv
// Run-request, memory read port and instruction bus of the MAC array sequencer.
// The sequencer takes the slave side; whoever issues runs and consumes reads takes the master side.
interface mac_array_ctrl_if #(
    parameter int row = 8,
    parameter int aw  = 11
);
    logic              start;
    logic              mode;
    logic [aw-1:0]     len;
    logic [aw-1:0]     w_base;
    logic [aw-1:0]     x_base;
    logic              busy;
    logic              done;
    logic              arr_rst;
    logic              rd_en;
    logic [aw-1:0]     rd_addr;
    logic [3*row-1:0]  inst_w;

    modport master (
        output start, mode, len, w_base, x_base,
        input  busy, done, arr_rst, rd_en, rd_addr, inst_w
    );

    modport slave (
        input  start, mode, len, w_base, x_base,
        output busy, done, arr_rst, rd_en, rd_addr, inst_w
    );
endinterface

// File: rtl/mac_array_ctrl_inst_skew.sv
// Delay line that fans the lane-0 instruction out to every row, with lane r
// lagging lane 0 by r cycles so each row sees its instruction with its data.
module inst_skew
    import mac_ctrl_pkg::*;
#(
    parameter int row = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  inst_t            lane0_i,
    output logic [3*row-1:0] inst_w_o
);

    assign inst_w_o[2:0] = lane0_i;

    if (row > 1) begin : g_chain
        inst_t chain_q [1:row-1];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int r = 1; r < row; r++) begin
                    chain_q[r] <= INST_IDLE;
                end
            end else begin
                chain_q[1] <= lane0_i;
                for (int r = 2; r < row; r++) begin
                    chain_q[r] <= chain_q[r-1];
                end
            end
        end

        for (genvar r = 1; r < row; r++) begin : g_lane
            assign inst_w_o[3*r +: 3] = chain_q[r];
        end
    end

endmodule

// File: rtl/mac_array_ctrl.sv
// West-edge sequencer for the systolic MAC array: clear, kernel load, execute, drain.
// Define MAC_CTRL_PERF_CNT_EN to add the 32-bit cycle_cnt run-length counter.
//
//   state | meaning
//   IDLE  | waiting for start; config latched on start
//   CLR   | one-cycle array clear pulse
//   LOAD  | col kernel reads from w_base
//   GAP   | col cycles with no reads so the load instruction clears the array
//   EXEC  | len activation reads from x_base (skipped when len is 0)
//   DRAIN | row+col cycles for the pipeline to empty
//   DONE  | one-cycle done pulse
module mac_array_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int row = 8,
    parameter int col = 8,
    parameter int aw  = 11
) (
    input  logic clk,
    input  logic reset,
    mac_array_ctrl_if.slave bus
`ifdef MAC_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt
`endif
);

    localparam int CW = (aw > 16) ? aw : 16;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic [aw-1:0]      len_q, len_d;
    logic [aw-1:0]      w_base_q, w_base_d;
    logic [aw-1:0]      x_base_q, x_base_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               arr_rst_q, arr_rst_d;
    logic               rd_en_q, rd_en_d;
    logic [aw-1:0]      rd_addr_q, rd_addr_d;
    inst_t              lane0_q, lane0_d;
    logic [3*row-1:0]   inst_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            len_q     <= '0;
            w_base_q  <= '0;
            x_base_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            arr_rst_q <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            lane0_q   <= INST_IDLE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            len_q     <= len_d;
            w_base_q  <= w_base_d;
            x_base_q  <= x_base_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            arr_rst_q <= arr_rst_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            lane0_q   <= lane0_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        len_d    = len_q;
        w_base_d = w_base_q;
        x_base_d = x_base_q;

        // cnt_q holds the cycles remaining in the current state minus one
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_CLR;
                    mode_d   = bus.mode;
                    len_d    = bus.len;
                    w_base_d = bus.w_base;
                    x_base_d = bus.x_base;
                end
            end
            ST_CLR: begin
                state_d = ST_LOAD;
                cnt_d   = CW'(col - 1);
            end
            ST_LOAD: begin
                if (cnt_q == 0) begin
                    state_d = ST_GAP;
                    cnt_d   = CW'(col - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == 0) begin
                    if (len_q == 0) begin
                        state_d = ST_DRAIN;
                        cnt_d   = CW'(row + col - 1);
                    end else begin
                        state_d = ST_EXEC;
                        cnt_d   = CW'(len_q) - CW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_EXEC: begin
                if (cnt_q == 0) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CW'(row + col - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == 0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        arr_rst_d = (state_d == ST_CLR);
        rd_en_d   = (state_d == ST_LOAD) || (state_d == ST_EXEC);

        rd_addr_d = rd_addr_q;
        if (state_d == ST_LOAD) begin
            rd_addr_d = (state_q == ST_LOAD) ? rd_addr_q + aw'(1) : w_base_q;
        end else if (state_d == ST_EXEC) begin
            rd_addr_d = (state_q == ST_EXEC) ? rd_addr_q + aw'(1) : x_base_q;
        end

        // Lane 0 trails the read by one cycle to meet the memory data
        lane0_d = INST_IDLE;
        if (state_q == ST_LOAD) begin
            lane0_d = INST_LOAD;
        end else if (state_q == ST_EXEC) begin
            lane0_d = INST_EXEC;
        end
        if (state_q != ST_IDLE) begin
            lane0_d[INST_BIT_MODE] = mode_q;
        end
    end

    inst_skew #(
        .row (row)
    ) u_inst_skew (
        .clk      (clk),
        .reset    (reset),
        .lane0_i  (lane0_q),
        .inst_w_o (inst_w)
    );

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.arr_rst = arr_rst_q;
    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.inst_w  = inst_w;

`ifdef MAC_CTRL_PERF_CNT_EN
    logic [31:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (state_q == ST_CLR) begin
            cyc_d = '0;
        end else if ((state_q != ST_IDLE) && (cyc_q != '1)) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign cycle_cnt = cyc_q;
`endif

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Self-checking bench for mac_array_ctrl: directed and randomized runs compared
// cycle by cycle against a timeline model built from the run length formulas.
module tb_mac_array_ctrl;
    import mac_ctrl_pkg::*;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int AW  = 11;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mac_array_ctrl_if #(.row(ROW), .aw(AW)) bus ();

`ifdef MAC_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt;
`endif

    mac_array_ctrl #(
        .row (ROW),
        .col (COL),
        .aw  (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus)
`ifdef MAC_CTRL_PERF_CNT_EN
        ,
        .cycle_cnt (cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state for the current run
    bit m_mode;
    int m_len;
    bit m_chain;
    bit m_prev_mode;

    function automatic int t_done();
        return 3*COL + ROW + m_len + 2;
    endfunction

    function automatic bit is_load(input int c);
        return (c >= 2) && (c <= COL + 1);
    endfunction

    function automatic bit is_exec(input int c);
        return (c >= 2*COL + 2) && (c <= 2*COL + 1 + m_len);
    endfunction

    // Lane-0 value at cycle c reflects what the sequencer did at cycle c-1
    function automatic logic [2:0] lane0(input int c);
        int p;
        p = c - 1;
        if (p < 0)  return m_chain ? {m_prev_mode, 2'b00} : 3'b000;
        if (p == 0) return 3'b000;
        if (p > t_done()) return 3'b000;
        return {m_mode, is_exec(p), is_load(p)};
    endfunction

    task automatic chk(input string tag, input int c, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    task automatic check_cycle(input int c, input bit ab, input int wb, input int xb);
        int d;
        logic [3:0] exp_ctl;
        logic [AW-1:0] exp_addr;
        logic [3*ROW-1:0] exp_inst;
        bit ld, ex;
        d  = t_done();
        ld = is_load(c);
        ex = is_exec(c);
        exp_inst = '0;
        if (ab) begin
            exp_ctl = 4'b0000;
        end else begin
            exp_ctl[3] = (c >= 1) && (c <= d);
            exp_ctl[2] = (c == d);
            exp_ctl[1] = (c == 1);
            exp_ctl[0] = ld || ex;
            for (int r = 0; r < ROW; r++) begin
                exp_inst[3*r +: 3] = lane0(c - r);
            end
        end
        chk("busy_done_clr_rden", c, {60'd0, bus.busy, bus.done, bus.arr_rst, bus.rd_en}, {60'd0, exp_ctl});
        if (ab) begin
            chk("rd_addr_reset", c, 64'(bus.rd_addr), 64'd0);
        end else if (ld) begin
            exp_addr = AW'(wb + c - 2);
            chk("rd_addr_load", c, 64'(bus.rd_addr), 64'(exp_addr));
        end else if (ex) begin
            exp_addr = AW'(xb + c - (2*COL + 2));
            chk("rd_addr_exec", c, 64'(bus.rd_addr), 64'(exp_addr));
        end
        chk("inst_w", c, 64'(bus.inst_w), 64'(exp_inst));
    endtask

    // Called at a falling edge, which becomes cycle 0 of the run (start high).
    task automatic run(input bit mode, input int len, input int wb, input int xb,
                       input int rst_at, input bit pulse_load, input bit pulse_done,
                       input bit chain_in, input bit chain_out, input bit prev_mode);
        int d;
        int last;
        bit ab;
        m_mode      = mode;
        m_len       = len;
        m_chain     = chain_in;
        m_prev_mode = prev_mode;
        d = t_done();
        bus.start  = 1'b1;
        bus.mode   = mode;
        bus.len    = AW'(len);
        bus.w_base = AW'(wb);
        bus.x_base = AW'(xb);
        if (chain_out)       last = d + 1;
        else if (rst_at > 0) last = rst_at + ROW + 2;
        else                 last = d + ROW + 2;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            ab = (rst_at > 0) && (c > rst_at);
            bus.start = 1'b0;
            check_cycle(c, ab, wb, xb);
`ifdef MAC_CTRL_PERF_CNT_EN
            if (!ab && c == d + 1) chk("cycle_cnt", c, 64'(cycle_cnt), 64'(d - 1));
            if (ab && c == rst_at + 1) chk("cycle_cnt_reset", c, 64'(cycle_cnt), 64'd0);
`endif
            // Config inputs wander during the run; only the start-time values count
            bus.mode   = 1'($urandom);
            bus.len    = AW'($urandom);
            bus.w_base = AW'($urandom);
            bus.x_base = AW'($urandom);
            if (pulse_load && c == 4) bus.start = 1'b1;
            if ((pulse_done || chain_out) && c == d) bus.start = 1'b1;
            if (chain_out && c == d + 1) bus.start = 1'b1;
            if (rst_at > 0) reset = (c == rst_at);
        end
    endtask

    initial begin
        bit pm;
        int rl;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.mode   = 1'b0;
        bus.len    = '0;
        bus.w_base = '0;
        bus.x_base = '0;
        repeat (2) @(negedge clk);
        m_mode = 1'b0; m_len = 0; m_chain = 1'b0; m_prev_mode = 1'b0;
        chk("reset_ctl", 0, {60'd0, bus.busy, bus.done, bus.arr_rst, bus.rd_en}, 64'd0);
        chk("reset_addr", 0, 64'(bus.rd_addr), 64'd0);
        chk("reset_inst", 0, 64'(bus.inst_w), 64'd0);
        reset = 1'b0;

        // Nominal run: done at cycle 50
        run(1'b1, 16, 'h010, 'h100, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Empty execute phase: done at cycle 34, no exec bits
        run(1'b0, 0, 'h3A0, 'h200, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Activation address wrap-around
        run(1'b1, 4, 'h123, 'h7FE, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Kernel address wrap-around
        run(1'b0, 3, 'h7FB, 'h055, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Reset in the middle of EXEC abandons the run
        run(1'b1, 16, 'h010, 'h100, 25, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Full run straight after the abort
        run(1'b1, 16, 'h010, 'h100, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Start pulses in LOAD and in DONE are ignored
        run(1'b0, 5, 'h200, 'h300, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // Start held through DONE launches a second run
        run(1'b1, 16, 'h010, 'h100, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run(1'b0, 2, 'h040, 'h080, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Randomized runs
        pm = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bit mo;
            bit ch;
            mo = 1'($urandom);
            rl = $urandom_range(0, 30);
            ch = (i % 3 == 1);
            run(mo, rl, $urandom_range(0, 2047), $urandom_range(0, 2047), 0,
                1'($urandom), 1'b0, (i % 3 == 2), ch, pm);
            pm = mo;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_array_ctrl.md
# mac_array_ctrl

Sequencer for the west edge of the row×col systolic MAC array. On a start request it clears the array, streams one kernel column-set through the tiles (kernel-load instruction), then streams `len` activation vectors (execute instruction) and drains the pipeline. It drives the shared input-memory read port and the per-row 3-bit instruction bus, skewing that bus one cycle per row. It reports completion with a one-cycle `done` pulse.

## Interface
- `row`, 8: array rows; one instruction lane per row.
- `col`, 8: array columns; number of kernel-load cycles.
- `aw`, 11: input-memory address width; also the width of `len`.
- `clk` in 1: clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high; one clock, this polarity and synchronicity are fixed.
- `start` in 1: run request; sampled in IDLE only.
- `mode` in 1: value driven on inst bit 2 for the whole run; latched at start.
- `len` in aw: number of execute vectors; latched at start.
- `w_base` in aw: kernel base address; latched at start.
- `x_base` in aw: activation base address; latched at start.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse in DONE.
- `arr_rst` out 1: array clear pulse; tiles re-arm kernel loading only through reset.
- `rd_en` out 1: input-memory read enable.
- `rd_addr` out aw: input-memory read address.
- `inst_w` out 3*row: lane r = bits [3r+2:3r]; bit 2 mode, bit 1 execute, bit 0 kernel load.

## Operation
- States: IDLE → CLR → LOAD → GAP → EXEC → DRAIN → DONE → IDLE.
- IDLE: `start`=1 latches `mode`, `len`, `w_base`, `x_base` and moves to CLR. `start` in any other state is ignored.
- CLR: 1 cycle, `arr_rst`=1.
- LOAD: `col` cycles; `rd_en`=1, `rd_addr`=`w_base`+k for k=0..col-1.
- GAP: `col` cycles; `rd_en`=0. This gives the load instruction time to clear the array before execute.
- EXEC: `len` cycles; `rd_en`=1, `rd_addr`=`x_base`+t. If `len`=0, EXEC is skipped (GAP → DRAIN).
- DRAIN: `row`+`col` cycles; `rd_en`=0.
- DONE: 1 cycle; `done`=1; then IDLE.
- Address arithmetic is modulo 2^aw. Wrap-around is legal and silent.
- Lane-0 instruction is registered one cycle after the matching read (1-cycle memory latency), so it aligns with read data:
  - inst = {mode,0,1} for a LOAD read;
  - inst = {mode,1,0} for an EXEC read;
  - inst = {mode,0,0} otherwise.
- Lane r equals lane 0 delayed r cycles.
- Bit 2 carries the latched `mode` on every non-idle lane cycle. Each lane returns to 000 once its skew pipeline empties.
- `reset` at any time: state IDLE; skew pipeline and latched config cleared; in-flight run abandoned without `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `arr_rst`=0, `rd_en`=0, `rd_addr`=0, `inst_w`=0.
- All outputs are registered.
- `start` high at cycle 0 (in IDLE), with k = 0..col-1:
  - CLR at cycle 1.
  - First LOAD read at cycle 2.
  - Lane 0 = 001|mode at cycles 3..col+2.
  - Lane r shifted by r.
- EXEC reads occupy cycles 2col+2 .. 2col+1+len.
- `done` at cycle 3col+row+len+2. With defaults and `len`=16 this is cycle 50.
- `busy` rises at cycle 1 and falls the cycle after `done`.
- Back-to-back runs: `start` held high through DONE starts the next run from IDLE one cycle later. Minimum idle gap is 1 cycle.

## Configuration
- `MAC_CTRL_PERF_CNT_EN` defined: adds output `cycle_cnt` (32 bits).
  - Cleared in CLR; increments every cycle while `busy`; holds its value in IDLE until the next run.
  - Saturates at all-ones.
  - Reset value 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

## Structure
- Package `mac_ctrl_pkg` holds:
  - the state enum;
  - instruction bit-position constants (MODE=2, EXEC=1, LOAD=0);
  - the 3-bit instruction type and the idle/load/exec instruction constants.
- Sub-module `inst_skew` (parameter `row`) is a triangular delay line that fans lane 0 out to `row` lanes with lane r delayed r cycles. It is synchronously reset.

## Test plan
- Default params; `start` with `len`=16, `w_base`=0x010, `x_base`=0x100, `mode`=1:
  - `arr_rst` at cycle 1;
  - `rd_addr` 0x010..0x017 at cycles 2..9;
  - `rd_addr` 0x100..0x10F at cycles 18..33;
  - `done` at cycle 50.
- Check lane skew: lane 0 = 101 at cycles 3..10; lane 7 = 101 at cycles 10..17; lane 3 = 110 at cycles 22..37.
- Run with `len`=0: no EXEC reads; `done` at cycle 34; no lane ever shows bit 1 set.
- Run with `x_base`=0x7FE, `len`=4: addresses 0x7FE, 0x7FF, 0x000, 0x001.
- `reset` asserted during EXEC:
  - all outputs 0 next cycle;
  - no `done`;
  - a new `start` runs a full sequence with correct timing.
- `start` pulsed during LOAD and during DONE: the LOAD pulse is ignored. A `start` held through DONE begins a second run. With `MAC_CTRL_PERF_CNT_EN` defined, `cycle_cnt` = 49 after a `len`=16 run.
